// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the my_mips_cpu instruction-fetch stage.
//   - bus widths (InstAddrBus / InstBus), default reset PC, NOP encoding
//   - if_upd_e: the action the IF/ID register takes in a given cycle
//   - helpers that classify an action as a valid load or a bubble load
// Optional feature macro used by the files that import this package:
//   IF_PERF_CNT_EN
// -----------------------------------------------------------------------------
package if_stage_pkg;

   localparam int          IF_ADDR_W   = 32;            // InstAddrBus
   localparam int          IF_INST_W   = 32;            // InstBus
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

   // IF/ID update action, listed in priority order.
   typedef enum logic [2:0] {
      UPD_RESET     = 3'd0,  // synchronous reset
      UPD_BRANCH    = 3'd1,  // redirect: squash IF/ID, skid and in-flight word
      UPD_SKID_LOAD = 3'd2,  // stalled with a word returning: park it in the skid
      UPD_HOLD      = 3'd3,  // stalled, nothing returning
      UPD_DRAIN     = 3'd4,  // released: IF/ID takes the parked word
      UPD_PASS      = 3'd5,  // IF/ID takes the returning ROM word
      UPD_BUBBLE    = 3'd6   // nothing to present: invalid entry
   } if_upd_e;

   function automatic logic upd_loads_valid(input if_upd_e u);
      return (u == UPD_DRAIN) || (u == UPD_PASS);
   endfunction

   function automatic logic upd_loads_bubble(input if_upd_e u);
      return (u == UPD_BRANCH) || (u == UPD_BUBBLE);
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundle of every non-clock signal of the fetch stage.
//   ROM side   : rom_addr_o, rom_ce_o (stage -> ROM), rom_data_i (ROM -> stage)
//   decode side: stall_i, branch_i, branch_target_i (decode -> stage)
//                id_pc_o, id_inst_o, id_valid_o (stage -> decode)
//   IF_PERF_CNT_EN: perf_fetch_o, perf_bubble_o (stage -> observer)
// Handshake: the stage presents an IF/ID entry whenever id_valid_o is high;
// decode accepts it on every rising edge where stall_i is low, and while
// stall_i is high the entry is held unchanged. rom_ce_o high means the ROM
// word for rom_addr_o is captured at this edge and appears on rom_data_i in
// the following cycle.
// Modports: master = the fetch stage, slave = its environment (ROM + decode).
// -----------------------------------------------------------------------------
interface if_stage_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic [ADDR_W-1:0] rom_addr_o;
   logic              rom_ce_o;
   logic [INST_W-1:0] rom_data_i;
   logic              stall_i;
   logic              branch_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic [ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0] id_inst_o;
   logic              id_valid_o;
`ifdef IF_PERF_CNT_EN
   logic [31:0]       perf_fetch_o;
   logic [31:0]       perf_bubble_o;
`endif

   modport master (
      output rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o,
`ifdef IF_PERF_CNT_EN
      output perf_fetch_o, perf_bubble_o,
`endif
      input  rom_data_i, stall_i, branch_i, branch_target_i
   );

   modport slave (
      input  rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o,
`ifdef IF_PERF_CNT_EN
      input  perf_fetch_o, perf_bubble_o,
`endif
      output rom_data_i, stall_i, branch_i, branch_target_i
   );

endinterface

// File: rtl/if_stage_skid_buf.sv
// -----------------------------------------------------------------------------
// if_stage_skid_buf
// One-entry buffer (pc + inst + valid) that parks the ROM word which returns
// while decode is stalled.
//   clk, rst        : clock, synchronous active-high reset
//   i_flush         : drop the entry (branch redirect); beats load/drain
//   i_load          : capture {i_pc, i_inst}, entry becomes valid
//   i_drain         : entry consumed by IF/ID, becomes invalid
//   o_valid/o_pc/o_inst : stored entry
// -----------------------------------------------------------------------------
module if_stage_skid_buf #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_load,
   input  logic              i_drain,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [INST_W-1:0] i_inst,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_pc,
   output logic [INST_W-1:0] o_inst
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_inst  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_inst  <= i_inst;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_inst  = r_inst;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of my_mips_cpu, sitting in front of a synchronous
// (1-cycle latency) instruction ROM.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : if_stage_if.master
//          rom_addr_o  registered PC
//          rom_ce_o    combinational issue strobe
//          rom_data_i  word for the address issued last cycle
//          stall_i / branch_i / branch_target_i from decode
//          id_pc_o / id_inst_o / id_valid_o  IF/ID register
// Parameters: ADDR_W, INST_W, RESET_PC.
// Optional feature macro IF_PERF_CNT_EN adds perf_fetch_o / perf_bubble_o.
//
// Storage is IF/ID + skid + one in-flight request. Issue is suppressed while
// stalled with a word already in flight or parked, so a returning word always
// has somewhere to go and nothing is lost except on branch or reset.
// -----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = IF_ADDR_W,
   parameter int                INST_W   = IF_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic       clk,
   input  logic       rst,
   if_stage_if.master bus
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
   localparam logic [INST_W-1:0] NOP     = INST_W'(IF_NOP_INST);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_req_pc;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_id_pc;
   logic [INST_W-1:0] r_id_inst;
   logic              r_id_valid;

   logic              w_issue;
   if_upd_e           w_upd;
   logic [ADDR_W-1:0] w_target;
   logic              w_skid_valid;
   logic [ADDR_W-1:0] w_skid_pc;
   logic [INST_W-1:0] w_skid_inst;
   logic              w_unused_tgt_lsb;

   // Redirect targets are word aligned; the low bits are dropped.
   assign w_target         = {bus.branch_target_i[ADDR_W-1:2], 2'b00};
   assign w_unused_tgt_lsb = ^bus.branch_target_i[1:0];

   // Issue only if the returning word is guaranteed a slot next cycle.
   assign w_issue = !rst && !bus.branch_i &&
                    !(bus.stall_i && (r_req_valid || w_skid_valid));

   always_comb begin
      w_upd = UPD_BUBBLE;
      if (rst)                w_upd = UPD_RESET;
      else if (bus.branch_i)  w_upd = UPD_BRANCH;
      else if (bus.stall_i)   w_upd = r_req_valid ? UPD_SKID_LOAD : UPD_HOLD;
      else if (w_skid_valid)  w_upd = UPD_DRAIN;
      else if (r_req_valid)   w_upd = UPD_PASS;
      else                    w_upd = UPD_BUBBLE;
   end

   // PC and in-flight request tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_req_pc    <= '0;
         r_req_valid <= 1'b0;
      end else if (bus.branch_i) begin
         r_pc        <= w_target;
         r_req_valid <= 1'b0;
      end else begin
         r_req_valid <= w_issue;
         if (w_issue) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
         end
      end
   end

   // IF/ID register.
   always_ff @(posedge clk) begin
      unique case (w_upd)
         UPD_RESET: begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP;
            r_id_pc    <= '0;
         end
         UPD_BRANCH, UPD_BUBBLE: begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP;
         end
         UPD_DRAIN: begin
            r_id_valid <= 1'b1;
            r_id_pc    <= w_skid_pc;
            r_id_inst  <= w_skid_inst;
         end
         UPD_PASS: begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_req_pc;
            r_id_inst  <= bus.rom_data_i;
         end
         default: begin
            // UPD_HOLD / UPD_SKID_LOAD: IF/ID keeps its entry.
         end
      endcase
   end

   if_stage_skid_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.branch_i),
      .i_load  (w_upd == UPD_SKID_LOAD),
      .i_drain (w_upd == UPD_DRAIN),
      .i_pc    (r_req_pc),
      .i_inst  (bus.rom_data_i),
      .o_valid (w_skid_valid),
      .o_pc    (w_skid_pc),
      .o_inst  (w_skid_inst)
   );

   a_no_skid_and_req : assert property (@(posedge clk) disable iff (rst)
      !(w_skid_valid && r_req_valid));

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_bubble;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetch  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (upd_loads_valid(w_upd))  r_perf_fetch  <= r_perf_fetch + 32'd1;
         if (upd_loads_bubble(w_upd)) r_perf_bubble <= r_perf_bubble + 32'd1;
      end
   end

   assign bus.perf_fetch_o  = r_perf_fetch;
   assign bus.perf_bubble_o = r_perf_bubble;
`endif

   assign bus.rom_addr_o = r_pc;
   assign bus.rom_ce_o   = w_issue;
   assign bus.id_pc_o    = r_id_pc;
   assign bus.id_inst_o  = r_id_inst;
   assign bus.id_valid_o = r_id_valid;

endmodule
